arbiter_req_agent: RTL and testbench

ARBITER_REQ_AGENT -- requirements
Module: arbiter_req_agent

---
 rtl/arbiter_req_agent.sv | 133 +++++++++++++
 tb/tb_arbiter_req_agent.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_req_agent.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_req_agent
//  Description : Per-client request agent for a round-robin arbiter. Holds one
//                payload per client, raises requests, converts one-hot grants
//                into pushes of {payload, id} into a 2-deep FWFT output FIFO,
//                throttles the arbiter so every grant has a free slot, and
//                flags illegal grants with a sticky error bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbiter_req_agent #(
    parameter  int CLIENTS    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int IDW        = $clog2(CLIENTS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [CLIENTS-1:0]            i_cli_valid,
    input  logic [CLIENTS*DATA_WIDTH-1:0] i_cli_data,
    output logic [CLIENTS-1:0]            o_cli_ready,
    output logic [CLIENTS-1:0]            o_req,
    input  logic [CLIENTS-1:0]            i_gnt,
    output logic                          o_block_arb,
    output logic                          o_out_valid,
    output logic [DATA_WIDTH-1:0]         o_out_data,
    output logic [IDW-1:0]                o_out_id,
    input  logic                          i_out_ready,
    output logic                          o_err_gnt
);

    localparam logic [CLIENTS-1:0] C_ONE = {{(CLIENTS-1){1'b0}}, 1'b1};

    // Holding registers, one entry per client
    logic [CLIENTS-1:0]    r_hold_vld_q;
    logic [CLIENTS-1:0]    w_hold_vld_d;
    logic [DATA_WIDTH-1:0] r_hold_data_q [CLIENTS];

    // Output FIFO state (depth 2)
    logic [DATA_WIDTH-1:0] r_fifo_data_q [2];
    logic [IDW-1:0]        r_fifo_id_q   [2];
    logic                  r_wr_ptr_q;
    logic                  r_rd_ptr_q;
    logic [1:0]            r_count_q;
    logic [1:0]            w_count_d;
    logic                  r_err_q;

    // Grant qualification
    logic                  w_gnt_any;
    logic                  w_gnt_onehot;
    logic [CLIENTS-1:0]    w_gnt_ok;
    logic                  w_gnt_bad;
    logic [CLIENTS-1:0]    w_load;
    logic                  w_push;
    logic                  w_pop;
    logic [IDW-1:0]        w_push_id;
    logic [DATA_WIDTH-1:0] w_push_data;

    // A grant is only honoured when it is one-hot and hits a held entry;
    // anything else is reported and otherwise ignored.
    assign w_gnt_any    = |i_gnt;
    assign w_gnt_onehot = w_gnt_any && ((i_gnt & (i_gnt - C_ONE)) == '0);
    assign w_gnt_ok     = w_gnt_onehot ? (i_gnt & r_hold_vld_q) : '0;
    assign w_gnt_bad    = w_gnt_any & (~w_gnt_onehot | (|(i_gnt & ~r_hold_vld_q)));

    // A granted slot is free again this cycle, so a new offer loads without a bubble
    assign o_cli_ready  = ~r_hold_vld_q | w_gnt_ok;
    assign w_load       = i_cli_valid & o_cli_ready;
    // Mask the request of a client whose grant is in flight so it is never granted twice
    assign o_req        = r_hold_vld_q & ~i_gnt;
    assign w_hold_vld_d = (r_hold_vld_q & ~w_gnt_ok) | w_load;

    assign w_push       = |w_gnt_ok;
    assign w_pop        = o_out_valid & i_out_ready;
    assign w_count_d    = r_count_q + {1'b0, w_push} - {1'b0, w_pop};
    // Hold the arbiter whenever the FIFO will be full after this edge, so the
    // grant issued next cycle always finds room
    assign o_block_arb  = (w_count_d == 2'd2);

    assign o_out_valid  = (r_count_q != 2'd0);
    assign o_out_data   = r_fifo_data_q[r_rd_ptr_q];
    assign o_out_id     = r_fifo_id_q[r_rd_ptr_q];
    assign o_err_gnt    = r_err_q;

    // Select the payload and index of the (one-hot) granted client
    always_comb begin
        w_push_id   = '0;
        w_push_data = '0;
        for (int k = 0; k < CLIENTS; k++) begin
            if (w_gnt_ok[k]) begin
                w_push_id   = IDW'(k);
                w_push_data = r_hold_data_q[k];
            end
        end
    end

    // Control state: hold valids, FIFO pointers/count and sticky error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_vld_q <= '0;
            r_wr_ptr_q   <= 1'b0;
            r_rd_ptr_q   <= 1'b0;
            r_count_q    <= 2'd0;
            r_err_q      <= 1'b0;
        end else begin
            r_hold_vld_q <= w_hold_vld_d;
            r_count_q    <= w_count_d;
            if (w_push) begin
                r_wr_ptr_q <= ~r_wr_ptr_q;
            end
            if (w_pop) begin
                r_rd_ptr_q <= ~r_rd_ptr_q;
            end
            if (w_gnt_bad) begin
                r_err_q <= 1'b1;
            end
        end
    end

    // Payload storage: qualified by the valid bits, so no reset is needed
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < CLIENTS; k++) begin
            if (w_load[k]) begin
                r_hold_data_q[k] <= i_cli_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (w_push) begin
            r_fifo_data_q[r_wr_ptr_q] <= w_push_data;
            r_fifo_id_q[r_wr_ptr_q]   <= w_push_id;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arbiter_req_agent.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbiter_req_agent
//  Description : Directed self-checking bench for arbiter_req_agent, with a
//                small registered round-robin arbiter model for the
//                closed-loop rotation scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_req_agent;

    localparam int CL = 4;
    localparam int DW = 8;

    logic           clk;
    logic           rst_n;
    logic [CL-1:0]  cli_valid;
    logic [CL*DW-1:0] cli_data;
    logic [CL-1:0]  cli_ready;
    logic [CL-1:0]  req;
    logic [CL-1:0]  gnt;
    logic [CL-1:0]  man_gnt;
    logic [CL-1:0]  arb_gnt;
    logic [1:0]     arb_ptr;
    logic           arb_en;
    logic           block_arb;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic [1:0]     out_id;
    logic           out_ready;
    logic           err_gnt;

    int n_chk;
    int n_fail;

    assign gnt = arb_en ? arb_gnt : man_gnt;

    arbiter_req_agent #(
        .CLIENTS    (CL),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cli_valid (cli_valid),
        .i_cli_data  (cli_data),
        .o_cli_ready (cli_ready),
        .o_req       (req),
        .i_gnt       (gnt),
        .o_block_arb (block_arb),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_id    (out_id),
        .i_out_ready (out_ready),
        .o_err_gnt   (err_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [3:0] g;
        g = '0;
        for (int i = 1; i <= 4; i++) begin
            int k;
            k = (int'(p) + i) % 4;
            if (g == '0 && r[k]) g[k] = 1'b1;
        end
        return g;
    endfunction

    // Registered round-robin arbiter: grant follows the request by one cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_gnt <= '0;
            arb_ptr <= 2'd3;
        end else if (!arb_en || block_arb) begin
            arb_gnt <= '0;
        end else begin
            arb_gnt <= rr_pick(req, arb_ptr);
            for (int i = 0; i < 4; i++) begin
                if (rr_pick(req, arb_ptr) == (4'b0001 << i)) arb_ptr <= 2'(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; cli_valid = '0; cli_data = '0; man_gnt = '0;
        arb_en = 1'b0; out_ready = 1'b0;
        tick(); tick();
        // Reset values
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_block", 32'(block_arb), 32'h0);
        chk("rst_cli_ready", 32'(cli_ready), 32'hF);
        chk("rst_err", 32'(err_gnt), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single client 1 with payload A5
        cli_valid = 4'b0010; cli_data[8 +: 8] = 8'hA5; out_ready = 1'b1; #1;
        chk("s1_ready", 32'(cli_ready), 32'hF);
        tick(); cli_valid = '0; #1;
        chk("s1_req", 32'(req), 32'h2);
        chk("s1_nov", 32'(out_valid), 32'h0);
        tick(); man_gnt = 4'b0010; #1;
        chk("s1_req_masked", 32'(req), 32'h0);
        chk("s1_block", 32'(block_arb), 32'h0);
        chk("s1_ready_g", 32'(cli_ready), 32'hF);
        tick(); man_gnt = '0; #1;
        chk("s1_valid", 32'(out_valid), 32'h1);
        chk("s1_data", 32'(out_data), 32'hA5);
        chk("s1_id", 32'(out_id), 32'h1);
        tick();
        chk("s1_drained", 32'(out_valid), 32'h0);

        // Grant and same-cycle reload on client 3
        cli_valid = 4'b1000; cli_data[24 +: 8] = 8'h11; #1;
        tick(); cli_valid = '0; #1;
        chk("rl_req", 32'(req), 32'h8);
        tick(); man_gnt = 4'b1000; cli_valid = 4'b1000; cli_data[24 +: 8] = 8'h22; #1;
        chk("rl_ready", 32'(cli_ready), 32'hF);
        tick(); man_gnt = '0; cli_valid = '0; #1;
        chk("rl_v1", 32'(out_valid), 32'h1);
        chk("rl_d1", 32'(out_data), 32'h11);
        chk("rl_id1", 32'(out_id), 32'h3);
        chk("rl_req2", 32'(req), 32'h8);
        tick(); man_gnt = 4'b1000; #1;
        chk("rl_gap", 32'(out_valid), 32'h0);
        tick(); man_gnt = '0; #1;
        chk("rl_d2", 32'(out_data), 32'h22);
        chk("rl_id2", 32'(out_id), 32'h3);
        tick();
        chk("rl_end_v", 32'(out_valid), 32'h0);
        chk("rl_end_req", 32'(req), 32'h0);

        // Backpressure: FIFO fills at 2, arbiter held, drains in grant order
        out_ready = 1'b0;
        cli_valid = 4'b0111; cli_data[0 +: 8] = 8'hC0; cli_data[8 +: 8] = 8'hC1;
        cli_data[16 +: 8] = 8'hC2; #1;
        tick(); cli_valid = '0; #1;
        chk("bp_req", 32'(req), 32'h7);
        tick(); man_gnt = 4'b0001; #1;
        chk("bp_block0", 32'(block_arb), 32'h0);
        tick(); man_gnt = 4'b0010; #1;
        chk("bp_id0", 32'(out_id), 32'h0);
        chk("bp_block1", 32'(block_arb), 32'h1);
        tick(); man_gnt = '0; #1;
        chk("bp_full_block", 32'(block_arb), 32'h1);
        chk("bp_req_left", 32'(req), 32'h4);
        tick();
        chk("bp_hold_id", 32'(out_id), 32'h0);
        chk("bp_hold_data", 32'(out_data), 32'hC0);
        chk("bp_hold_block", 32'(block_arb), 32'h1);
        out_ready = 1'b1; #1;
        chk("bp_unblock", 32'(block_arb), 32'h0);
        tick(); man_gnt = 4'b0100; #1;
        chk("bp_id1", 32'(out_id), 32'h1);
        chk("bp_data1", 32'(out_data), 32'hC1);
        chk("bp_block_pp", 32'(block_arb), 32'h0);
        tick(); man_gnt = '0; #1;
        chk("bp_id2", 32'(out_id), 32'h2);
        chk("bp_data2", 32'(out_data), 32'hC2);
        tick();
        chk("bp_empty", 32'(out_valid), 32'h0);

        // Closed loop with the round-robin arbiter, all clients offering
        arb_en = 1'b1; cli_valid = 4'hF;
        cli_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0}; #1;
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) begin
            chk("rr_valid", 32'(out_valid), 32'h1);
            chk("rr_id", 32'(out_id), 32'(i % 4));
            chk("rr_data", 32'(out_data), 32'(8'hD0 + (i % 4)));
            tick();
        end

        // Queue 2 payloads with 3 still held, then reset mid-transfer
        arb_en = 1'b0; cli_valid = '0; out_ready = 1'b0; #1;
        tick(); man_gnt = 4'b0001; #1;
        chk("mr_block", 32'(block_arb), 32'h1);
        tick(); man_gnt = '0; #1;
        chk("mr_valid", 32'(out_valid), 32'h1);
        chk("mr_req", 32'(req), 32'hE);
        rst_n = 1'b0; #1;
        chk("mr_rst_req", 32'(req), 32'h0);
        chk("mr_rst_valid", 32'(out_valid), 32'h0);
        chk("mr_rst_block", 32'(block_arb), 32'h0);
        chk("mr_rst_ready", 32'(cli_ready), 32'hF);
        tick(); rst_n = 1'b1; man_gnt = 4'b0001; #1;
        chk("mr_post_ready", 32'(cli_ready), 32'hF);
        chk("mr_post_valid", 32'(out_valid), 32'h0);
        tick(); man_gnt = '0; #1;
        chk("mr_err", 32'(err_gnt), 32'h1);
        chk("mr_no_stale", 32'(out_valid), 32'h0);
        chk("mr_no_req", 32'(req), 32'h0);

        // Grant to an idle client
        rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
        chk("er_clear", 32'(err_gnt), 32'h0);
        man_gnt = 4'b0100; #1;
        tick(); man_gnt = '0; #1;
        chk("er_idle", 32'(err_gnt), 32'h1);
        chk("er_idle_nov", 32'(out_valid), 32'h0);

        // Multi-hot grant with both targets held: discarded, state unchanged
        rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
        cli_valid = 4'b0011; cli_data[0 +: 8] = 8'hE0; cli_data[8 +: 8] = 8'hE1; #1;
        tick(); cli_valid = '0; #1;
        chk("mh_req", 32'(req), 32'h3);
        chk("mh_err0", 32'(err_gnt), 32'h0);
        man_gnt = 4'b0011; #1;
        chk("mh_ready", 32'(cli_ready), 32'hC);
        chk("mh_block", 32'(block_arb), 32'h0);
        tick(); man_gnt = '0; #1;
        chk("mh_err", 32'(err_gnt), 32'h1);
        chk("mh_nov", 32'(out_valid), 32'h0);
        chk("mh_req_kept", 32'(req), 32'h3);
        tick();
        chk("mh_sticky", 32'(err_gnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
